apb_arbiter: RTL
================

Name: apb_arbiter

Overview:
- Shares one downstream APB port between NREQ upstream APB requesters, e.g. core data port and debug module.
- The downstream port drives the core-side APB fabric that splits cfgreg from intc on paddr[27].
- Round-robin arbitration, one transfer at a time, grant held until the downstream transfer completes.
- Downstream setup/access phases are regenerated from registered copies of the winning request.

Parameters:
NREQ, 2, number of upstream requesters (2..8)
ADDR_W, 32, paddr width
DATA_W, 32, pwdata/prdata width

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
req_psel  input  NREQ  per-requester psel
req_penable  input  NREQ  per-requester penable
req_paddr  input  NREQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
req_pwrite  input  NREQ  per-requester pwrite
req_pstrb  input  NREQ*DATA_W/8  packed pstrb
req_pprot  input  NREQ*3  packed pprot
req_pwdata  input  NREQ*DATA_W  packed pwdata
req_prdata  output  DATA_W  shared read data, valid only with that requester's pready
req_pslverr  output  NREQ  per-requester pslverr
req_pready  output  NREQ  per-requester pready
m_psel, m_penable, m_pwrite  output  1 each  downstream control
m_paddr  output  ADDR_W  downstream address
m_pstrb  output  DATA_W/8  downstream strobes
m_pprot  output  3  downstream protection
m_pwdata  output  DATA_W  downstream write data
m_prdata  input  DATA_W  downstream read data
m_pslverr, m_pready  input  1 each  downstream response
gnt_id  output  $clog2(NREQ)  currently/last granted requester (debug)

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; m_psel=m_penable=0; m_paddr/m_pwrite/m_pstrb/m_pprot/m_pwdata=0.
  - gnt_id=0; rr pointer=NREQ-1, so requester 0 wins the first tie.
  - Reset mid-transfer aborts silently; no pready is returned.
- State machine:
  - IDLE: if any req_psel is set, pick winner W by round-robin starting at ptr+1 mod NREQ. Register W's paddr/pwrite/pstrb/pprot/pwdata into the m_* regs, set gnt_id=W and ptr=W, go to SETUP. Otherwise stay.
  - SETUP: m_psel=1, m_penable=0; go to ACCESS unconditionally.
  - ACCESS: m_psel=1, m_penable=1. If m_pready: req_pready[W]=1 and req_pslverr[W]=m_pslverr for this cycle (combinational pass-through), req_prdata=m_prdata, next state IDLE. Otherwise hold, with all m_* stable.
- Outputs outside the completion cycle:
  - req_pready and req_pslverr are 0 for all requesters in every other cycle.
  - Non-granted requesters are stalled.
  - req_prdata = m_prdata at all times; requesters sample it only with their own pready.
- Latency: request visible in IDLE at cycle N → downstream setup at N+1 → access at N+2 → earliest req_pready at N+2. Back-to-back transfers pass through one IDLE cycle, so the minimum transfer period is 3 cycles.
- Fairness: a requester holding psel is granted within NREQ transfers.
- Simultaneous requests: resolved by pointer order only; upstream penable is not considered.
- Upstream psel drops while granted (protocol violation): the downstream transfer still completes and the response is discarded; no pready goes to any requester.
- m_pslverr is forwarded only to W.

Decomposition:
- Package apb_arb_pkg holds the state enum {IDLE, SETUP, ACCESS}, the 2-bit state type, and the PPROT_W=3 constant.
- Sub-module rr_pick: combinational round-robin picker, inputs req[NREQ] and ptr, outputs the one-hot grant and its index. It is instantiated once.

Test Plan:
- Single read from req0, paddr=0x0800_0010, downstream pready after 2 wait states, m_prdata=0xDEAD_BEEF → req_pready[0] high exactly 1 cycle with req_prdata=0xDEAD_BEEF; req_pready[1] stays 0.
- req0 and req1 both assert psel in the same cycle after reset → req0 served first, then req1. With both held continuously, grants alternate 0,1,0,1; period is 3 cycles with zero wait states.
- req1 write paddr=0x0000_0004, pwdata=0x1234_5678, pstrb=4'b0011 → m_* match exactly in SETUP and stay stable through 3 ACCESS wait cycles.
- Downstream m_pslverr=1 on a req1 transfer → req_pslverr[1]=1 only in its pready cycle; req_pslverr[0]=0 throughout.
- rstn low during ACCESS → next cycle m_psel=m_penable=0, no req_pready, gnt_id=0; the following request from req1 alone is granted.
- req0 drops psel during ACCESS → downstream completes on m_pready, no req_pready is asserted, and the FSM returns to IDLE.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and constants for the APB arbiter
package apb_arb_pkg;

    localparam int PPROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts just after ptr
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        // offset NREQ wraps back to ptr itself, so the last winner has lowest priority
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - round-robin sharing of one downstream APB port among NREQ requesters
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NREQ-1:0]                   req_psel,
    input  logic [NREQ-1:0]                   req_penable,
    input  logic [NREQ*ADDR_W-1:0]            req_paddr,
    input  logic [NREQ-1:0]                   req_pwrite,
    input  logic [NREQ*(DATA_W/8)-1:0]        req_pstrb,
    input  logic [NREQ*PPROT_W-1:0]           req_pprot,
    input  logic [NREQ*DATA_W-1:0]            req_pwdata,
    output logic [DATA_W-1:0]                 req_prdata,
    output logic [NREQ-1:0]                   req_pslverr,
    output logic [NREQ-1:0]                   req_pready,
    output logic                              m_psel,
    output logic                              m_penable,
    output logic                              m_pwrite,
    output logic [ADDR_W-1:0]                 m_paddr,
    output logic [DATA_W/8-1:0]               m_pstrb,
    output logic [PPROT_W-1:0]                m_pprot,
    output logic [DATA_W-1:0]                 m_pwdata,
    input  logic [DATA_W-1:0]                 m_prdata,
    input  logic                              m_pslverr,
    input  logic                              m_pready,
    output logic [$clog2(NREQ)-1:0]           gnt_id
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int STRB_W = DATA_W / 8;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [NREQ-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             completing;
    logic             unused_penable;

    // arbitration deliberately ignores upstream penable
    assign unused_penable = ^req_penable;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req_psel),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            ptr      <= IDX_W'(NREQ - 1);
            gnt_id   <= '0;
            m_paddr  <= '0;
            m_pwrite <= 1'b0;
            m_pstrb  <= '0;
            m_pprot  <= '0;
            m_pwdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick_gnt) begin
                        m_paddr  <= req_paddr[pick_idx*ADDR_W +: ADDR_W];
                        m_pwrite <= req_pwrite[pick_idx];
                        m_pstrb  <= req_pstrb[pick_idx*STRB_W +: STRB_W];
                        m_pprot  <= req_pprot[pick_idx*PPROT_W +: PPROT_W];
                        m_pwdata <= req_pwdata[pick_idx*DATA_W +: DATA_W];
                        gnt_id   <= pick_idx;
                        ptr      <= pick_idx;
                        state    <= SETUP;
                    end
                end
                SETUP:   state <= ACCESS;
                ACCESS:  if (m_pready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign m_psel     = (state != IDLE);
    assign m_penable  = (state == ACCESS);
    assign completing = (state == ACCESS) && m_pready;
    assign req_prdata = m_prdata;

    // a requester that dropped psel mid-transfer gets no response at all
    always_comb begin
        req_pready  = '0;
        req_pslverr = '0;
        if (completing && req_psel[gnt_id]) begin
            req_pready[gnt_id]  = 1'b1;
            req_pslverr[gnt_id] = m_pslverr;
        end
    end

endmodule
